// File: rtl/avalon_dual_slave_shared_ram_if.sv
// One Avalon-MM slave port: command, waitrequest backpressure and pipelined read return.
// The master drives the command and must hold it while waitrequest is high.
interface avalon_dual_slave_shared_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic                    waitrequest;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avalon_dual_slave_shared_ram.sv
// Shared single-port RAM behind two round-robin arbitrated Avalon-MM slaves; reads return READ_LATENCY
// enabled cycles after accept. Backpressure via waitrequest on the losing port, on clken=0 and on reset_req.
module avalon_dual_slave_shared_ram #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 6,
    parameter int    DEPTH        = 64,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clken,
    input  logic                             reset_req,
    avalon_dual_slave_shared_ram_if.slave    s1,
    avalon_dual_slave_shared_ram_if.slave    s2
);
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        GRANT_S1 = 1'b0,
        GRANT_S2 = 1'b1
    } grant_e;

    grant_e last_grant;
    grant_e last_grant_nxt;

    logic                  allow;
    logic                  req1;
    logic                  req2;
    logic                  grant1;
    logic                  grant2;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [BE_W-1:0]       cmd_be;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  cmd_write;
    logic                  cmd_in_range;
    logic [RAM_AW-1:0]     ram_idx;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Arbitration: a lone requester always wins, a tie goes to the port not granted last.
    always_comb begin
        req1           = s1.read | s1.write;
        req2           = s2.read | s2.write;
        allow          = clken & ~reset_req & ~reset;
        grant1         = allow & req1 & (~req2 | (last_grant == GRANT_S2));
        grant2         = allow & req2 & (~req1 | (last_grant == GRANT_S1));
        accept         = grant1 | grant2;
        last_grant_nxt = last_grant;
        if (grant1) begin
            last_grant_nxt = GRANT_S1;
        end else if (grant2) begin
            last_grant_nxt = GRANT_S2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_S2;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    assign s1.waitrequest = req1 & ~grant1;
    assign s2.waitrequest = req2 & ~grant2;

    always_comb begin
        cmd_addr     = grant2 ? s2.address    : s1.address;
        cmd_be       = grant2 ? s2.byteenable : s1.byteenable;
        cmd_wdata    = grant2 ? s2.writedata  : s1.writedata;
        cmd_write    = grant2 ? s2.write      : s1.write;
        cmd_in_range = ({1'b0, cmd_addr} < ADDR_LIMIT);
        ram_idx      = cmd_addr[RAM_AW-1:0];
        // Out-of-range writes are accepted but never reach the array.
        wr_en        = accept & cmd_write & cmd_in_range;
        rd_en        = accept & ~cmd_write;
        rd_word      = cmd_in_range ? mem[ram_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (cmd_be[b]) begin
                    mem[ram_idx][b*8 +: 8] <= cmd_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read return pipeline: the final stage drives readdatavalid, load1/load2 update the per-port data.
    logic                  fin_vld;
    logic                  fin_tag;
    logic                  load1;
    logic                  load2;
    logic [DATA_WIDTH-1:0] load_dat;
    logic [DATA_WIDTH-1:0] rdat1;
    logic [DATA_WIDTH-1:0] rdat2;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  st1_vld;
            logic                  st1_tag;
            logic [DATA_WIDTH-1:0] st1_dat;
            logic                  st2_vld;
            logic                  st2_tag;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    st1_vld <= 1'b0;
                    st1_tag <= 1'b0;
                    st1_dat <= '0;
                    st2_vld <= 1'b0;
                    st2_tag <= 1'b0;
                end else if (clken) begin
                    st1_vld <= rd_en;
                    if (rd_en) begin
                        st1_tag <= grant2;
                        st1_dat <= rd_word;
                    end
                    st2_vld <= st1_vld;
                    st2_tag <= st1_tag;
                end
            end

            assign fin_vld  = st2_vld;
            assign fin_tag  = st2_tag;
            assign load_dat = st1_dat;
            assign load1    = clken & st1_vld & ~st1_tag;
            assign load2    = clken & st1_vld & st1_tag;
        end else begin : g_lat1
            logic st1_vld;
            logic st1_tag;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    st1_vld <= 1'b0;
                    st1_tag <= 1'b0;
                end else if (clken) begin
                    st1_vld <= rd_en;
                    if (rd_en) begin
                        st1_tag <= grant2;
                    end
                end
            end

            assign fin_vld  = st1_vld;
            assign fin_tag  = st1_tag;
            assign load_dat = rd_word;
            assign load1    = rd_en & grant1;
            assign load2    = rd_en & grant2;
        end
    endgenerate

    // Each port keeps its own data register so the idle port's readdata holds its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdat1 <= '0;
            rdat2 <= '0;
        end else begin
            if (load1) begin
                rdat1 <= load_dat;
            end
            if (load2) begin
                rdat2 <= load_dat;
            end
        end
    end

    assign s1.readdata      = rdat1;
    assign s2.readdata      = rdat2;
    assign s1.readdatavalid = clken & fin_vld & ~fin_tag;
    assign s2.readdatavalid = clken & fin_vld & fin_tag;
endmodule

// File: tb/tb_avalon_dual_slave_shared_ram.sv
// Drives identical traffic into a DEPTH=48/LAT=1 and a DEPTH=64/LAT=2 instance and checks both
// against a per-cycle reference model plus directed vectors and corner sequences.
module tb_avalon_dual_slave_shared_ram;
    localparam int DW      = 32;
    localparam int AW      = 6;
    localparam int DEPTH_A = 48;
    localparam int DEPTH_B = 64;
    localparam int LAT_A   = 1;
    localparam int LAT_B   = 2;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic clken     = 1'b1;
    logic reset_req = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] c_addr [2];
    logic [3:0]    c_be   [2];
    logic          c_rd   [2];
    logic          c_wr   [2];
    logic [DW-1:0] c_wd   [2];

    avalon_dual_slave_shared_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_s1 ();
    avalon_dual_slave_shared_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_s2 ();
    avalon_dual_slave_shared_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b_s1 ();
    avalon_dual_slave_shared_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b_s2 ();

    assign a_s1.address = c_addr[0]; assign a_s1.byteenable = c_be[0]; assign a_s1.read = c_rd[0];
    assign a_s1.write   = c_wr[0];   assign a_s1.writedata  = c_wd[0];
    assign a_s2.address = c_addr[1]; assign a_s2.byteenable = c_be[1]; assign a_s2.read = c_rd[1];
    assign a_s2.write   = c_wr[1];   assign a_s2.writedata  = c_wd[1];
    assign b_s1.address = c_addr[0]; assign b_s1.byteenable = c_be[0]; assign b_s1.read = c_rd[0];
    assign b_s1.write   = c_wr[0];   assign b_s1.writedata  = c_wd[0];
    assign b_s2.address = c_addr[1]; assign b_s2.byteenable = c_be[1]; assign b_s2.read = c_rd[1];
    assign b_s2.write   = c_wr[1];   assign b_s2.writedata  = c_wd[1];

    avalon_dual_slave_shared_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH_A), .READ_LATENCY(LAT_A), .INIT_FILE("")
    ) dut_a (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .s1(a_s1), .s2(a_s2)
    );

    avalon_dual_slave_shared_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH_B), .READ_LATENCY(LAT_B), .INIT_FILE("")
    ) dut_b (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .s1(b_s1), .s2(b_s2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: word arrays per instance, a queue of reads owed, and an enabled-cycle count.
    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    logic [DW-1:0] mm [2][64];
    rd_t pq0 [$];
    rd_t pq1 [$];
    int  lg   = 1;
    int  tick = 0;
    bit  acc [2];

    task automatic model_accept(input int p);
        for (int d = 0; d < 2; d++) begin
            int  dep;
            rd_t e;
            dep = (d == 0) ? DEPTH_A : DEPTH_B;
            if (c_wr[p]) begin
                if (int'(c_addr[p]) < dep)
                    for (int b = 0; b < 4; b++)
                        if (c_be[p][b]) mm[d][c_addr[p]][b*8 +: 8] = c_wd[p][b*8 +: 8];
            end else begin
                e.port = p;
                e.data = (int'(c_addr[p]) < dep) ? mm[d][c_addr[p]] : 32'h0;
                e.due  = tick + ((d == 0) ? LAT_A : LAT_B);
                if (d == 0) pq0.push_back(e); else pq1.push_back(e);
            end
        end
    endtask

    task automatic deliver(input int d, input logic v1, input logic [DW-1:0] r1,
                           input logic v2, input logic [DW-1:0] r2);
        rd_t h;
        bit  e1 = 0;
        bit  e2 = 0;
        h.port = 0; h.data = '0; h.due = 0;
        if (clken) begin
            if (d == 0 && pq0.size() > 0 && pq0[0].due == tick) h = pq0.pop_front();
            else if (d == 1 && pq1.size() > 0 && pq1[0].due == tick) h = pq1.pop_front();
            else h.due = -1;
            if (h.due >= 0) begin
                e1 = (h.port == 0);
                e2 = (h.port == 1);
            end
        end
        chk($sformatf("dut%0d_s1_rdv", d), v1, e1);
        chk($sformatf("dut%0d_s2_rdv", d), v2, e2);
        if (e1) chk($sformatf("dut%0d_s1_rdata", d), r1, h.data);
        if (e2) chk($sformatf("dut%0d_s2_rdata", d), r2, h.data);
    endtask

    always @(negedge clk) begin : monitor
        bit al, r0, r1, g0, g1;
        if (reset) begin
            chk("rst_a_s1_rdv", a_s1.readdatavalid, 0); chk("rst_a_s1_rdata", a_s1.readdata, 0);
            chk("rst_a_s2_rdv", a_s2.readdatavalid, 0); chk("rst_a_s2_rdata", a_s2.readdata, 0);
            chk("rst_b_s1_rdv", b_s1.readdatavalid, 0); chk("rst_b_s1_rdata", b_s1.readdata, 0);
            chk("rst_b_s2_rdv", b_s2.readdatavalid, 0); chk("rst_b_s2_rdata", b_s2.readdata, 0);
            pq0.delete();
            pq1.delete();
            lg = 1;
            acc[0] = 0;
            acc[1] = 0;
        end else begin
            al = clken && !reset_req;
            r0 = c_rd[0] || c_wr[0];
            r1 = c_rd[1] || c_wr[1];
            g0 = al && r0 && (!r1 || lg == 1);
            g1 = al && r1 && (!r0 || lg == 0);
            chk("a_s1_wait", a_s1.waitrequest, r0 && !g0);
            chk("a_s2_wait", a_s2.waitrequest, r1 && !g1);
            chk("b_s1_wait", b_s1.waitrequest, r0 && !g0);
            chk("b_s2_wait", b_s2.waitrequest, r1 && !g1);
            deliver(0, a_s1.readdatavalid, a_s1.readdata, a_s2.readdatavalid, a_s2.readdata);
            deliver(1, b_s1.readdatavalid, b_s1.readdata, b_s2.readdatavalid, b_s2.readdata);
            if (g0) begin model_accept(0); lg = 0; end
            if (g1) begin model_accept(1); lg = 1; end
            acc[0] = g0;
            acc[1] = g1;
            if (clken) tick++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int p = 0; p < 2; p++) begin
            c_rd[p] = 0; c_wr[p] = 0; c_addr[p] = '0; c_be[p] = '0; c_wd[p] = '0;
        end
    endtask

    task automatic set_cmd(input int p, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [3:0] be);
        c_rd[p] = !wr; c_wr[p] = wr; c_addr[p] = addr; c_wd[p] = wd; c_be[p] = be;
    endtask

    task automatic do_cmd(input int p, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [3:0] be);
        bit ok = 0;
        set_cmd(p, wr, addr, wd, be);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = !((p == 0) ? a_s1.waitrequest : a_s2.waitrequest);
            step();
        end
        c_rd[p] = 0;
        c_wr[p] = 0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_rdv(input int p, input logic [DW-1:0] exp, input string nm);
        bit got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? a_s1.readdatavalid : a_s2.readdatavalid) begin
                got = 1;
                chk(nm, (p == 0) ? a_s1.readdata : a_s2.readdata, exp);
            end
            step();
        end
        if (!got) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic pulse_reset();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    typedef struct {
        int            port;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [3:0]    be;
        logic [DW-1:0] exp;
    } vec_t;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tbl [12];
        int   nv [2];
        int   k  [2];
        tbl[0]  = '{0, 1'b1, 6'd5,  32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1]  = '{0, 1'b0, 6'd5,  32'h0,        4'h0, 32'hDEADBEEF};
        tbl[2]  = '{0, 1'b1, 6'd5,  32'h000000AA, 4'h1, 32'h0};
        tbl[3]  = '{0, 1'b0, 6'd5,  32'h0,        4'h0, 32'hDEADBEAA};
        tbl[4]  = '{1, 1'b1, 6'd50, 32'h12345678, 4'hF, 32'h0};
        tbl[5]  = '{1, 1'b0, 6'd50, 32'h0,        4'h0, 32'h0};
        tbl[6]  = '{1, 1'b0, 6'd2,  32'h0,        4'h0, 32'h0};
        tbl[7]  = '{1, 1'b1, 6'd7,  32'hA5A5A5A5, 4'hC, 32'h0};
        tbl[8]  = '{0, 1'b0, 6'd7,  32'h0,        4'h0, 32'hA5A50000};
        tbl[9]  = '{0, 1'b1, 6'd47, 32'hCAFEF00D, 4'hF, 32'h0};
        tbl[10] = '{1, 1'b0, 6'd47, 32'h0,        4'h0, 32'hCAFEF00D};
        tbl[11] = '{0, 1'b0, 6'd48, 32'h0,        4'h0, 32'h0};
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++) mm[d][w] = '0;
        idle_all();

        // Reset state
        repeat (3) begin
            @(negedge clk);
            chk("rst_a_s1_wait", a_s1.waitrequest, 0);
            chk("rst_b_s2_wait", b_s2.waitrequest, 0);
            step();
        end
        reset = 0;

        for (int w = 0; w < 64; w++) do_cmd(0, 1'b1, AW'(w), 32'h0, 4'hF);

        // Directed vectors (expectations for the DEPTH=48, LAT=1 instance)
        for (int i = 0; i < 12; i++) begin
            do_cmd(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be);
            if (!tbl[i].wr) wait_rdv(tbl[i].port, tbl[i].exp, $sformatf("vec%0d_rdata", i));
        end

        // Both ports read every cycle straight after reset: s1 wins first, then strict alternation
        pulse_reset();
        nv[0] = 0; nv[1] = 0; k[0] = 0; k[1] = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                set_cmd(0, 1'b0, AW'(10 + k[0]), 32'h0, 4'h0);
                set_cmd(1, 1'b0, AW'(20 + k[1]), 32'h0, 4'h0);
            end else idle_all();
            @(negedge clk);
            if (i < 6) begin
                chk("t3_s1_wait", a_s1.waitrequest, i % 2);
                chk("t3_s2_wait", a_s2.waitrequest, (i + 1) % 2);
                if (!a_s1.waitrequest) k[0]++;
                if (!a_s2.waitrequest) k[1]++;
            end
            nv[0] += int'(a_s1.readdatavalid);
            nv[1] += int'(a_s2.readdatavalid);
            step();
        end
        chk("t3_s1_valids", nv[0], 3);
        chk("t3_s2_valids", nv[1], 3);

        // Back-to-back s2 reads 0..3: LAT=2 valids at offsets 2..5, LAT=1 at 1..4
        for (int o = 0; o < 10; o++) begin
            if (o < 4) set_cmd(1, 1'b0, AW'(o), 32'h0, 4'h0); else idle_all();
            @(negedge clk);
            chk($sformatf("t4_b_rdv_o%0d", o), b_s2.readdatavalid, (o >= 2 && o <= 5));
            chk($sformatf("t4_a_rdv_o%0d", o), a_s2.readdatavalid, (o >= 1 && o <= 4));
            step();
        end

        // clken low freezes an in-flight read and blocks accepts
        set_cmd(0, 1'b0, 6'd5, 32'h0, 4'h0);
        @(negedge clk);
        chk("t6_accept", a_s1.waitrequest, 0);
        step();
        idle_all();
        clken = 0;
        set_cmd(1, 1'b0, 6'd6, 32'h0, 4'h0);
        repeat (3) begin
            @(negedge clk);
            chk("t6_frozen_a_rdv", a_s1.readdatavalid, 0);
            chk("t6_frozen_b_rdv", b_s1.readdatavalid, 0);
            chk("t6_frozen_s2_wait", a_s2.waitrequest, 1);
            step();
        end
        clken = 1;
        @(negedge clk);
        chk("t6_resume_a_rdv", a_s1.readdatavalid, 1);
        chk("t6_resume_a_rdata", a_s1.readdata, 32'hDEADBEAA);
        chk("t6_resume_b_rdv", b_s1.readdatavalid, 0);
        chk("t6_resume_s2_wait", a_s2.waitrequest, 0);
        step();
        idle_all();
        @(negedge clk);
        chk("t6_resume2_b_rdv", b_s1.readdatavalid, 1);
        chk("t6_resume2_b_rdata", b_s1.readdata, 32'hDEADBEAA);
        chk("t6_resume2_a_s2_rdv", a_s2.readdatavalid, 1);
        step();
        repeat (3) step();

        // Reset while a read is in flight drops it
        do_cmd(0, 1'b0, 6'd5, 32'h0, 4'h0);
        reset = 1;
        @(negedge clk);
        chk("t6_rst_a_rdv", a_s1.readdatavalid, 0);
        chk("t6_rst_a_rdata", a_s1.readdata, 0);
        step();
        step();
        reset = 0;
        repeat (4) begin
            @(negedge clk);
            chk("t6_post_rst_a_rdv", a_s1.readdatavalid, 0);
            chk("t6_post_rst_b_rdv", b_s1.readdatavalid, 0);
            step();
        end

        // reset_req blocks new commands while an accepted read drains
        do_cmd(0, 1'b0, 6'd7, 32'h0, 4'h0);
        reset_req = 1;
        set_cmd(0, 1'b0, 6'd8, 32'h0, 4'h0);
        set_cmd(1, 1'b0, 6'd9, 32'h0, 4'h0);
        @(negedge clk);
        chk("rr_s1_wait", a_s1.waitrequest, 1);
        chk("rr_s2_wait", a_s2.waitrequest, 1);
        chk("rr_a_rdv", a_s1.readdatavalid, 1);
        chk("rr_a_rdata", a_s1.readdata, 32'hA5A50000);
        step();
        @(negedge clk);
        chk("rr_b_rdv", b_s1.readdatavalid, 1);
        chk("rr_b_rdata", b_s1.readdata, 32'hA5A50000);
        chk("rr_s1_wait2", b_s1.waitrequest, 1);
        step();
        reset_req = 0;
        idle_all();
        step();

        // Randomized traffic with clken and reset_req noise, commands held while waitrequest
        for (int i = 0; i < 800; i++) begin
            clken     = ($urandom % 8) != 0;
            reset_req = ($urandom % 16) == 0;
            for (int p = 0; p < 2; p++) begin
                if (!(c_rd[p] || c_wr[p]) || acc[p]) begin
                    int r;
                    r = $urandom % 8;
                    if (r < 2) begin
                        c_rd[p] = 0; c_wr[p] = 0;
                    end else begin
                        c_wr[p]   = (r >= 5);
                        c_rd[p]   = (r < 5) || (r == 7);
                        c_addr[p] = AW'($urandom % 64);
                        c_be[p]   = 4'($urandom);
                        c_wd[p]   = $urandom;
                    end
                end
            end
            step();
        end
        clken = 1;
        reset_req = 0;
        idle_all();
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
